// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: 24Cxx-style I2C EEPROM target with a 16-bit word pointer.
// SCL/SDA are oversampled on sys_clk; a write-cycle busy window NACKs the device.
module i2c_eeprom_slave #(
   parameter logic [6:0] DEV_ADDR       = 7'b1010000,
   parameter int         ADDR_W         = 8,
   parameter int         WR_BUSY_CYCLES = 1000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic        busy,
   output logic        wr_pulse,
   output logic [15:0] wr_addr
);

   localparam int BW = $clog2(WR_BUSY_CYCLES + 1);

   typedef enum logic [3:0] {
      IDLE,
      DEVADDR,
      ACK_DEV,
      ADDR_HI,
      ACK_HI,
      ADDR_LO,
      ACK_LO,
      WR_DATA,
      ACK_WR,
      RD_DATA,
      MACK,
      IGNORE
   } state_t;

   // [0] metastable stage, [1] synced value, [2] history for edges
   logic [2:0] scl_sync_q;
   logic [2:0] sda_sync_q;

   state_t          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      hi_q, hi_d;
   logic [15:0]     ptr_q, ptr_d;
   logic            rw_q, rw_d;
   logic [7:0]      tx_q, tx_d;
   logic            sda_oe_q, sda_oe_d;
   logic            wr_pulse_q, wr_pulse_d;
   logic [15:0]     wr_addr_q, wr_addr_d;
   logic            committed_q, committed_d;
   logic [BW-1:0]   busy_cnt_q, busy_cnt_d;

   logic [7:0] mem [2**ADDR_W];
   logic       mem_we;

   logic scl_s, scl_p, sda_s, sda_p;
   logic scl_rise, scl_fall, start_det, stop_det;
   logic last_bit, rx_state;
   logic [7:0] rx_byte, rd_byte;

   assign scl_s = scl_sync_q[1];
   assign scl_p = scl_sync_q[2];
   assign sda_s = sda_sync_q[1];
   assign sda_p = sda_sync_q[2];

   assign scl_rise  = scl_s & ~scl_p;
   assign scl_fall  = ~scl_s & scl_p;
   assign start_det = scl_s & scl_p & sda_p & ~sda_s;
   assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

   assign last_bit = (bit_cnt_q == 3'd7);
   assign rx_byte  = {shift_q[6:0], sda_s};
   assign rd_byte  = mem[ptr_q[ADDR_W-1:0]];
   assign rx_state = (state_q == DEVADDR) || (state_q == ADDR_HI) ||
                     (state_q == ADDR_LO) || (state_q == WR_DATA);

   assign busy     = (busy_cnt_q != '0);
   assign sda_oe   = sda_oe_q;
   assign wr_pulse = wr_pulse_q;
   assign wr_addr  = wr_addr_q;

   // Pad synchronizers; idle bus level is high
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], scl_in};
         sda_sync_q <= {sda_sync_q[1:0], sda_in};
      end
   end

   // Storage array is deliberately left unreset
   always_ff @(posedge sys_clk) begin
      if (mem_we) mem[ptr_q[ADDR_W-1:0]] <= rx_byte;
   end

   // Protocol state and datapath registers
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         hi_q        <= '0;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         tx_q        <= '0;
         sda_oe_q    <= 1'b0;
         wr_pulse_q  <= 1'b0;
         wr_addr_q   <= '0;
         committed_q <= 1'b0;
         busy_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         hi_q        <= hi_d;
         ptr_q       <= ptr_d;
         rw_q        <= rw_d;
         tx_q        <= tx_d;
         sda_oe_q    <= sda_oe_d;
         wr_pulse_q  <= wr_pulse_d;
         wr_addr_q   <= wr_addr_d;
         committed_q <= committed_d;
         busy_cnt_q  <= busy_cnt_d;
      end
   end

   // Next-state: bus events first, then per-state bit handling
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      hi_d        = hi_q;
      ptr_d       = ptr_q;
      rw_d        = rw_q;
      tx_d        = tx_q;
      sda_oe_d    = sda_oe_q;
      wr_pulse_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      committed_d = committed_q;
      busy_cnt_d  = busy ? busy_cnt_q - BW'(1) : busy_cnt_q;
      mem_we      = 1'b0;

      if (start_det) begin
         state_d     = DEVADDR;
         bit_cnt_d   = '0;
         sda_oe_d    = 1'b0;
         committed_d = 1'b0;
      end else if (stop_det) begin
         state_d     = IDLE;
         bit_cnt_d   = '0;
         sda_oe_d    = 1'b0;
         committed_d = 1'b0;
         if (committed_q) busy_cnt_d = BW'(WR_BUSY_CYCLES);
      end else begin
         if (rx_state && scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
         unique case (state_q)
            IDLE, IGNORE: ;
            DEVADDR: begin
               if (scl_rise && last_bit) begin
                  if (rx_byte[7:1] == DEV_ADDR && !busy) begin
                     state_d = ACK_DEV;
                     rw_d    = rx_byte[0];
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            ADDR_HI: begin
               if (scl_rise && last_bit) begin
                  hi_d    = rx_byte;
                  state_d = ACK_HI;
               end
            end
            ADDR_LO: begin
               if (scl_rise && last_bit) begin
                  ptr_d   = {hi_q, rx_byte};
                  state_d = ACK_LO;
               end
            end
            WR_DATA: begin
               if (scl_rise && last_bit) begin
                  mem_we      = 1'b1;
                  wr_pulse_d  = 1'b1;
                  wr_addr_d   = ptr_q;
                  ptr_d       = ptr_q + 16'd1;
                  committed_d = 1'b1;
                  state_d     = ACK_WR;
               end
            end
            ACK_DEV, ACK_HI, ACK_LO, ACK_WR: begin
               // sda_oe_q doubles as the "ACK bit in progress" phase flag
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                     if (state_q == ACK_DEV && rw_q) begin
                        state_d  = RD_DATA;
                        tx_d     = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                     end else if (state_q == ACK_DEV) begin
                        state_d = ADDR_HI;
                     end else if (state_q == ACK_HI) begin
                        state_d = ADDR_LO;
                     end else begin
                        state_d = WR_DATA;
                     end
                  end
               end
            end
            RD_DATA: begin
               if (scl_fall) sda_oe_d = ~tx_q[~bit_cnt_q];
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (last_bit) begin
                     ptr_d     = ptr_q + 16'd1;
                     bit_cnt_d = '0;
                     state_d   = MACK;
                  end
               end
            end
            MACK: begin
               if (scl_fall) sda_oe_d = 1'b0;
               if (scl_rise) begin
                  if (!sda_s) begin
                     state_d   = RD_DATA;
                     tx_d      = rd_byte;
                     bit_cnt_d = '0;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: I2C master driver with queue scoreboard and a
// byte-array EEPROM reference model.
module tb_i2c_eeprom_slave;

   localparam int Q = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic        sda_line;
   logic        sda_oe;
   logic        busy;
   logic        wr_pulse;
   logic [15:0] wr_addr;

   assign sda_line = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_eeprom_slave #(
      .DEV_ADDR(7'b1010000),
      .ADDR_W(8),
      .WR_BUSY_CYCLES(1000)
   ) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .scl_in  (scl_m),
      .sda_in  (sda_line),
      .sda_oe  (sda_oe),
      .busy    (busy),
      .wr_pulse(wr_pulse),
      .wr_addr (wr_addr)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] exp_wa[$];
   logic [7:0]  exp_rd[$];
   logic [7:0]  act_rd[$];
   logic        exp_ack[$];
   logic        act_ack[$];
   logic [7:0]  wbuf[$];

   logic [7:0]  mmem[256];
   logic [15:0] mptr = '0;

   int busy_run = 0;
   int busy_len = 0;
   logic watch_oe = 1'b0;
   int oe_seen = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic unexp(string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: DUT produced an output, required none", nm);
   endtask

   // scoreboard monitor: compares whatever the DUT/bus has presented
   always @(negedge clk) begin
      if (!rst && wr_pulse) begin
         if (exp_wa.size() == 0) unexp("wr_pulse");
         else chk("wr_addr", 32'(wr_addr), 32'(exp_wa.pop_front()));
      end
      while (act_ack.size() > 0) begin
         if (exp_ack.size() == 0) begin
            unexp("ack");
            void'(act_ack.pop_front());
         end else begin
            chk("ack_bit", 32'(act_ack.pop_front()), 32'(exp_ack.pop_front()));
         end
      end
      while (act_rd.size() > 0) begin
         if (exp_rd.size() == 0) begin
            unexp("rd_data");
            void'(act_rd.pop_front());
         end else begin
            chk("rd_data", 32'(act_rd.pop_front()), 32'(exp_rd.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (busy) begin
         busy_run <= busy_run + 1;
      end else if (busy_run != 0) begin
         busy_len <= busy_run;
         busy_run <= 0;
      end
      if (watch_oe && sda_oe) oe_seen <= oe_seen + 1;
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; cyc(Q);
      scl_m = 1'b1; cyc(Q);
      sda_m = 1'b0; cyc(Q);
      scl_m = 1'b0; cyc(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; cyc(Q);
      scl_m = 1'b1; cyc(Q);
      sda_m = 1'b1; cyc(Q);
   endtask

   task automatic send_byte(logic [7:0] b, logic e_ack);
      logic a;
      exp_ack.push_back(e_ack);
      for (int i = 7; i >= 0; i--) begin
         sda_m = b[i]; cyc(Q);
         scl_m = 1'b1; cyc(2 * Q);
         scl_m = 1'b0; cyc(Q);
      end
      sda_m = 1'b1; cyc(Q);
      scl_m = 1'b1; cyc(Q);
      a = sda_line; cyc(Q);
      scl_m = 1'b0; cyc(Q);
      act_ack.push_back(a);
   endtask

   task automatic read_byte(logic nack);
      logic [7:0] b;
      b = '0;
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         cyc(Q);
         scl_m = 1'b1; cyc(Q);
         b[i] = sda_line; cyc(Q);
         scl_m = 1'b0; cyc(Q);
      end
      sda_m = nack; cyc(Q);
      scl_m = 1'b1; cyc(2 * Q);
      scl_m = 1'b0; cyc(Q);
      sda_m = 1'b1;
      act_rd.push_back(b);
   endtask

   task automatic m_write(logic [15:0] a);
      i2c_start();
      send_byte(8'hA0, 1'b0);
      send_byte(a[15:8], 1'b0);
      send_byte(a[7:0], 1'b0);
      mptr = a;
      foreach (wbuf[i]) begin
         exp_wa.push_back(mptr);
         mmem[mptr[7:0]] = wbuf[i];
         mptr = mptr + 16'd1;
         send_byte(wbuf[i], 1'b0);
      end
      i2c_stop();
   endtask

   task automatic m_addr_only(logic [15:0] a);
      i2c_start();
      send_byte(8'hA0, 1'b0);
      send_byte(a[15:8], 1'b0);
      send_byte(a[7:0], 1'b0);
      mptr = a;
      i2c_stop();
   endtask

   task automatic read_body(int n);
      for (int k = 0; k < n; k++) begin
         exp_rd.push_back(mmem[mptr[7:0]]);
         mptr = mptr + 16'd1;
         read_byte(k == n - 1);
      end
      i2c_stop();
   endtask

   task automatic m_rand_read(logic [15:0] a, int n);
      i2c_start();
      send_byte(8'hA0, 1'b0);
      send_byte(a[15:8], 1'b0);
      send_byte(a[7:0], 1'b0);
      mptr = a;
      i2c_start();
      send_byte(8'hA1, 1'b0);
      read_body(n);
   endtask

   task automatic m_cur_read(int n);
      i2c_start();
      send_byte(8'hA1, 1'b0);
      read_body(n);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 3000) begin
         cyc(1);
         k++;
      end
      if (busy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", k);
      end
      cyc(4);
   endtask

   task automatic read_with_reset();
      logic [7:0] e;
      logic       e_oe;
      e = mmem[mptr[7:0]];
      e_oe = ~e[4];
      sda_m = 1'b1;
      for (int i = 7; i >= 4; i--) begin
         cyc(Q);
         if (i == 4) begin
            chk("rd_bit4_oe", 32'(sda_oe), 32'(e_oe));
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            chk("oe_after_rst", 32'(sda_oe), 32'd0);
         end else begin
            scl_m = 1'b1; cyc(2 * Q);
            scl_m = 1'b0; cyc(Q);
         end
      end
      mptr = '0;
      scl_m = 1'b1; cyc(Q);
      sda_m = 1'b1; cyc(Q);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [15:0] a;
      rst = 1'b1;
      cyc(5);
      @(negedge clk);
      chk("rst_sda_oe", 32'(sda_oe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      cyc(5);

      // single byte write and its busy window
      wbuf = '{8'h3C};
      m_write(16'h0005);
      wait_idle();
      chk("busy_len_byte", 32'(busy_len), 32'd1000);

      // random read of the byte just written
      m_rand_read(16'h0005, 1);
      cyc(5);

      // page write across the 8-bit memory index wrap
      wbuf = '{8'h11, 8'h22, 8'h33};
      m_write(16'h00FE);
      wait_idle();
      chk("busy_len_page", 32'(busy_len), 32'd1000);
      m_rand_read(16'h00FE, 3);
      cyc(5);

      // busy NACK; pointer left at 0x0100 (index 0)
      wbuf = '{8'($urandom)};
      m_write(16'h00FF);
      cyc(100);
      chk("busy_at_100", 32'(busy), 32'd1);
      i2c_start();
      send_byte(8'hA0, 1'b1);
      i2c_stop();
      wait_idle();
      i2c_start();
      send_byte(8'hA0, 1'b0);
      i2c_stop();
      cyc(5);
      chk("no_busy_ctrl_only", 32'(busy), 32'd0);
      m_cur_read(1);
      cyc(5);

      // wrong device address
      oe_seen = 0;
      watch_oe = 1'b1;
      i2c_start();
      send_byte(8'hA2, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h55, 1'b1);
      i2c_stop();
      cyc(5);
      watch_oe = 1'b0;
      chk("wrong_addr_oe", 32'(oe_seen), 32'd0);
      chk("wrong_addr_busy", 32'(busy), 32'd0);

      // address-only write moves the pointer only
      m_addr_only(16'h0005);
      cyc(5);
      chk("addr_only_busy", 32'(busy), 32'd0);
      m_cur_read(2);
      cyc(5);

      // randomized write / read-back rounds
      for (int r = 0; r < 8; r++) begin
         a = 16'($urandom);
         n = $urandom_range(1, 4);
         wbuf.delete();
         for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom));
         m_write(a);
         wait_idle();
         if ($urandom_range(0, 1) == 0) begin
            m_rand_read(a, n);
         end else begin
            m_addr_only(a);
            m_cur_read(n);
         end
         cyc(5);
      end

      // reset in the middle of a read byte
      wbuf = '{8'hE7};
      m_write(16'h0010);
      wait_idle();
      i2c_start();
      send_byte(8'hA0, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h10, 1'b0);
      mptr = 16'h0010;
      i2c_start();
      send_byte(8'hA1, 1'b0);
      read_with_reset();
      m_cur_read(1);

      cyc(50);
      chk("left_exp_wa", 32'(exp_wa.size()), 32'd0);
      chk("left_exp_rd", 32'(exp_rd.size()), 32'd0);
      chk("left_exp_ack", 32'(exp_ack.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

I2C target that emulates a 24Cxx-style serial EEPROM with 16-bit word addressing. It sits on the board-level SCL/SDA pair as the responder to the I2C master and the EEPROM read/write sequencer. It also serves as the synthesizable bus-functional model in the controller's system bench. It decodes START/STOP, matches the device address, loads a 16-bit word pointer, and stores written bytes. Reads are returned MSB-first with auto-incrementing address. After each write transaction it enforces an internal write-cycle busy time, during which it NACKs its address.

## Interface
- DEV_ADDR, 7'b1010000, 7-bit target address matched against the control byte.
- ADDR_W, 8, implemented memory address bits; depth is 2**ADDR_W bytes; only pointer[ADDR_W-1:0] is used.
- WR_BUSY_CYCLES, 1000, sys_clk cycles of write-cycle busy time following STOP of a write.

- sys_clk  in  1  system clock; must be ≥ 8× SCL frequency.
- sys_rst  in  1  synchronous, active-high reset.
- scl_in  in  1  SCL pad input, asynchronous.
- sda_in  in  1  SDA pad input, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release (open drain).
- busy  out  1  high during the write-cycle busy window.
- wr_pulse  out  1  one-cycle strobe when a data byte is committed to memory.
- wr_addr  out  16  full pointer value of the committed byte, valid with wr_pulse.

## Operation
- Input path: scl_in and sda_in each pass through a 2-FF synchronizer, plus one history register for edge detection.
- Bus events:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Data is sampled on detected SCL rise and driven on detected SCL fall.
- Bit counter: 3-bit counter plus 8-bit shift register, MSB first.
- States:
  - IDLE → DEVADDR on START.
  - DEVADDR: after 8 bits, compare [7:1] with DEV_ADDR.
    - Match and !busy → ACK_DEV.
    - Otherwise → IGNORE; SDA is released, which gives a NACK.
  - ACK_DEV:
    - R/W=0 → ADDR_HI.
    - R/W=1 → RD_DATA. This is a current-address read from the existing pointer.
  - ADDR_HI → ACK_HI → ADDR_LO → ACK_LO → WR_DATA. The pointer loads {hi, lo} when the 8th low-byte bit is sampled.
  - WR_DATA: on the 8th bit, write mem[pointer], pulse wr_pulse, then pointer += 1 → ACK_WR → WR_DATA.
  - RD_DATA: shift out mem[pointer] and release SDA for 1 bits. After bit 8, pointer += 1 → MACK.
  - MACK: sample master SDA on the SCL rise.
    - 0 (ACK) → RD_DATA with the next byte.
    - 1 (NACK) → IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- START in any state → DEVADDR, bit counter cleared. This covers repeated start for random read: write pointer, then re-START with R/W=1.
- STOP in any state → IDLE. If ≥1 byte was committed since the last START, busy asserts for WR_BUSY_CYCLES cycles.
- Pointer arithmetic: 16-bit, wraps 16'hFFFF → 0. Memory index wraps modulo 2**ADDR_W.
- Address-only write (START, ctrl, hi, lo, STOP) updates the pointer only. It sets no busy and produces no wr_pulse.
- Memory contents are not reset. On reset: pointer = 0, state = IDLE.

## Timing
- Reset values: sda_oe=0, busy=0, wr_pulse=0, wr_addr=0, state IDLE, bit counter 0, busy counter 0.
- Bus-event detection latency is 3 sys_clk from the pad edge: 2 sync stages plus 1 edge compare.
- ACK drive:
  - sda_oe asserts 1 cycle after the detected SCL fall that ends bit 8.
  - sda_oe releases 1 cycle after the detected SCL fall that ends the ACK bit.
- Read data: sda_oe updates 1 cycle after each detected SCL fall. The first read bit is driven after the fall ending ACK_DEV.
- wr_pulse and wr_addr appear 1 cycle after the SCL rise that samples bit 8 of a data byte.
- busy rises 1 cycle after STOP detection and stays high exactly WR_BUSY_CYCLES cycles.
- A START with matching address during busy is NACKed; the FSM goes to IGNORE.
- Simultaneous START detection and busy expiry in the same cycle: the address phase runs with busy sampled at the 8th bit.
- SDA changes while SCL high outside START/STOP (glitch) are treated as START/STOP per the rules above; no filtering.

## Test plan
- Byte write:
  - Stimulus: START, A0, 00, 05, 3C, STOP.
  - Required response: ACK on all 4 bytes; wr_pulse once with wr_addr=16'h0005; busy high 1000 cycles.
- Random read:
  - Stimulus: after the above and busy clear, START, A0, 00, 05, reSTART, A1, master NACK, STOP.
  - Required response: slave returns 8'h3C.
- Page write and sequential read with wrap:
  - Stimulus: write 11,22,33 starting at pointer 16'h00FE; then read 3 bytes from 16'h00FE with master ACK, ACK, NACK.
  - Required response: mem index wraps, wr_addr = 00FE, 00FF, 0100; read returns 11,22,33.
- Busy NACK:
  - Stimulus: START, A0 issued 100 cycles after a write STOP.
  - Required response: 9th-bit SDA released (NACK), no state change; the same access after busy clears is ACKed.
- Wrong address:
  - Stimulus: START, A2, 00, 00, 55, STOP.
  - Required response: sda_oe never asserted; no wr_pulse; busy stays 0.
- Reset mid-read:
  - Stimulus: assert sys_rst for 1 cycle while driving bit 4 of a read byte.
  - Required response: sda_oe=0 next cycle; FSM IDLE; next START, A1 reads mem[0].
